scm_rw_frontend: RTL and testbench

- Request/response front-end that sits directly upstream of the latch-based 1-write/N-read register file and drives its raw ports.
- Converts one valid/ready write channel and N_READ valid/ready read channels into the file's enable/address/data strobes.
- Absorbs the file's write-latch timing through same-cycle write-to-read forwarding.
- Holds read responses stable under backpressure, so consumers never see latch-transparency effects.

---
 rtl/scm_rw_frontend_pkg.sv | 23 ++
 rtl/scm_rw_frontend_rd_port.sv | 62 ++++++
 rtl/scm_rw_frontend.sv | 100 ++++++++++
 tb/tb_scm_rw_frontend.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scm_rw_frontend_pkg.sv
// Shared types and helpers for the scm_rw_frontend register-file front-end.
package scm_rw_frontend_pkg;

  localparam int unsigned PERF_CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    HOLD  = 2'd2
  } rd_state_e;

  function automatic int unsigned num_words(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  function automatic logic [PERF_CNT_W-1:0] sat_add(input logic [PERF_CNT_W-1:0] a,
                                                    input logic [PERF_CNT_W-1:0] b);
    logic [PERF_CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[PERF_CNT_W] ? '1 : s[PERF_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/scm_rw_frontend_rd_port.sv
// One read channel: request/response FSM with forward and hold registers.
module scm_rw_frontend_rd_port
  import scm_rw_frontend_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_fwd_hit,
  input  logic [DATA_WIDTH-1:0] i_fwd_data,
  input  logic [DATA_WIDTH-1:0] i_rf_data,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_data
);

  rd_state_e             r_state;
  rd_state_e             w_state_nxt;
  logic                  r_fwd_flag;
  logic [DATA_WIDTH-1:0] r_fwd_data;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic                  w_req_acc;
  logic [DATA_WIDTH-1:0] w_sel_data;

  always_comb begin
    w_state_nxt = r_state;
    o_req_ready = !rst && ((r_state == IDLE) || i_rsp_ready);
    o_rsp_valid = !rst && (r_state != IDLE);
    w_req_acc   = i_req_valid && o_req_ready;
    w_sel_data  = r_fwd_flag ? r_fwd_data : i_rf_data;
    // HOLD serves the captured copy so later writes cannot leak through the latch
    o_rsp_data  = (r_state == HOLD) ? r_hold_data : w_sel_data;
    unique case (r_state)
      IDLE:        if (w_req_acc) w_state_nxt = FIRST;
      FIRST, HOLD: begin
        if (!i_rsp_ready)   w_state_nxt = HOLD;
        else if (w_req_acc) w_state_nxt = FIRST;
        else                w_state_nxt = IDLE;
      end
      default:     w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_fwd_flag  <= 1'b0;
      r_fwd_data  <= '0;
      r_hold_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_req_acc) begin
        r_fwd_flag <= i_fwd_hit;
        r_fwd_data <= i_fwd_data;
      end
      if (r_state == FIRST) r_hold_data <= w_sel_data;
    end
  end

endmodule

// File: rtl/scm_rw_frontend.sv
// Valid/ready front-end for the latch-based 1W/NR register file.
// Optional performance counters enabled by SCM_RW_FRONTEND_PERF_CNT_EN.
module scm_rw_frontend
  import scm_rw_frontend_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_READ     = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 wr_valid_i,
  output logic                                 wr_ready_o,
  input  logic [ADDR_WIDTH-1:0]                wr_addr_i,
  input  logic [DATA_WIDTH-1:0]                wr_data_i,
  input  logic [N_READ-1:0]                    rd_req_valid_i,
  output logic [N_READ-1:0]                    rd_req_ready_o,
  input  logic [N_READ-1:0][ADDR_WIDTH-1:0]    rd_req_addr_i,
  output logic [N_READ-1:0]                    rd_rsp_valid_o,
  input  logic [N_READ-1:0]                    rd_rsp_ready_i,
  output logic [N_READ-1:0][DATA_WIDTH-1:0]    rd_rsp_data_o,
  output logic [N_READ-1:0]                    rf_read_en_o,
  output logic [N_READ-1:0][ADDR_WIDTH-1:0]    rf_read_addr_o,
  input  logic [N_READ-1:0][DATA_WIDTH-1:0]    rf_read_data_i,
  output logic                                 rf_write_en_o,
  output logic [ADDR_WIDTH-1:0]                rf_write_addr_o,
  output logic [DATA_WIDTH-1:0]                rf_write_data_o
`ifdef SCM_RW_FRONTEND_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0]                perf_wr_cnt_o,
  output logic [PERF_CNT_W-1:0]                perf_rd_cnt_o,
  output logic [PERF_CNT_W-1:0]                perf_fwd_cnt_o
`endif
);

  logic              w_wr_acc;
  logic [N_READ-1:0] w_fwd_hit;

  assign wr_ready_o      = !rst;
  assign w_wr_acc        = wr_valid_i && !rst;
  assign rf_write_en_o   = w_wr_acc;
  assign rf_write_addr_o = wr_addr_i;
  assign rf_write_data_o = wr_data_i;

  for (genvar p = 0; p < N_READ; p++) begin : g_rd
    // The file's latch only updates next cycle, so a same-cycle write must be forwarded
    assign w_fwd_hit[p]      = w_wr_acc && (wr_addr_i == rd_req_addr_i[p]);
    assign rf_read_en_o[p]   = rd_req_valid_i[p] && rd_req_ready_o[p];
    assign rf_read_addr_o[p] = rd_req_addr_i[p];

    scm_rw_frontend_rd_port #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_port (
      .clk         (clk),
      .rst         (rst),
      .i_req_valid (rd_req_valid_i[p]),
      .o_req_ready (rd_req_ready_o[p]),
      .i_fwd_hit   (w_fwd_hit[p]),
      .i_fwd_data  (wr_data_i),
      .i_rf_data   (rf_read_data_i[p]),
      .o_rsp_valid (rd_rsp_valid_o[p]),
      .i_rsp_ready (rd_rsp_ready_i[p]),
      .o_rsp_data  (rd_rsp_data_o[p])
    );
  end

`ifdef SCM_RW_FRONTEND_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] r_wr_cnt;
  logic [PERF_CNT_W-1:0] r_rd_cnt;
  logic [PERF_CNT_W-1:0] r_fwd_cnt;
  logic [PERF_CNT_W-1:0] w_rd_inc;
  logic [PERF_CNT_W-1:0] w_fwd_inc;

  always_comb begin
    w_rd_inc  = '0;
    w_fwd_inc = '0;
    for (int unsigned i = 0; i < N_READ; i++) begin
      w_rd_inc  = w_rd_inc  + PERF_CNT_W'(rf_read_en_o[i]);
      w_fwd_inc = w_fwd_inc + PERF_CNT_W'(rf_read_en_o[i] & w_fwd_hit[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_fwd_cnt <= '0;
    end else begin
      r_wr_cnt  <= sat_add(r_wr_cnt, PERF_CNT_W'(w_wr_acc));
      r_rd_cnt  <= sat_add(r_rd_cnt, w_rd_inc);
      r_fwd_cnt <= sat_add(r_fwd_cnt, w_fwd_inc);
    end
  end

  assign perf_wr_cnt_o  = r_wr_cnt;
  assign perf_rd_cnt_o  = r_rd_cnt;
  assign perf_fwd_cnt_o = r_fwd_cnt;
`endif

endmodule

// File: tb/tb_scm_rw_frontend.sv
// Directed bench for scm_rw_frontend with a latch-timed register file model.
module tb_scm_rw_frontend;
  import scm_rw_frontend_pkg::*;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 2;
  localparam int unsigned NW = num_words(AW);

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   wr_valid = 1'b0;
  logic                   wr_ready;
  logic [AW-1:0]          wr_addr = '0;
  logic [DW-1:0]          wr_data = '0;
  logic [NR-1:0]          req_valid = '0;
  logic [NR-1:0]          req_ready;
  logic [NR-1:0][AW-1:0]  req_addr = '0;
  logic [NR-1:0]          rsp_valid;
  logic [NR-1:0]          rsp_ready = '1;
  logic [NR-1:0][DW-1:0]  rsp_data;
  logic [NR-1:0]          rf_ren;
  logic [NR-1:0][AW-1:0]  rf_raddr;
  logic [NR-1:0][DW-1:0]  rf_rdata;
  logic                   rf_wen;
  logic [AW-1:0]          rf_waddr;
  logic [DW-1:0]          rf_wdata;
`ifdef SCM_RW_FRONTEND_PERF_CNT_EN
  logic [31:0]            perf_wr, perf_rd, perf_fwd;
`endif

  int checks = 0;
  int failures = 0;
  int cur = 0;

  always #5 clk = ~clk;

  scm_rw_frontend #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .N_READ     (NR)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .wr_valid_i      (wr_valid),
    .wr_ready_o      (wr_ready),
    .wr_addr_i       (wr_addr),
    .wr_data_i       (wr_data),
    .rd_req_valid_i  (req_valid),
    .rd_req_ready_o  (req_ready),
    .rd_req_addr_i   (req_addr),
    .rd_rsp_valid_o  (rsp_valid),
    .rd_rsp_ready_i  (rsp_ready),
    .rd_rsp_data_o   (rsp_data),
    .rf_read_en_o    (rf_ren),
    .rf_read_addr_o  (rf_raddr),
    .rf_read_data_i  (rf_rdata),
    .rf_write_en_o   (rf_wen),
    .rf_write_addr_o (rf_waddr),
    .rf_write_data_o (rf_wdata)
`ifdef SCM_RW_FRONTEND_PERF_CNT_EN
    ,
    .perf_wr_cnt_o   (perf_wr),
    .perf_rd_cnt_o   (perf_rd),
    .perf_fwd_cnt_o  (perf_fwd)
`endif
  );

  // Register file model: a write accepted in cycle t lands mid-cycle t+1,
  // read data follows the latched read address transparently.
  logic [DW-1:0]         mem [NW];
  logic                  pend_v = 1'b0;
  logic [AW-1:0]         pend_a;
  logic [DW-1:0]         pend_d;
  logic [NR-1:0][AW-1:0] m_raddr = '0;

  always @(posedge clk) begin
    pend_v <= rf_wen;
    pend_a <= rf_waddr;
    pend_d <= rf_wdata;
    for (int p = 0; p < NR; p++)
      if (rf_ren[p]) m_raddr[p] <= rf_raddr[p];
  end

  always @(negedge clk)
    if (pend_v) mem[pend_a] <= pend_d;

  always_comb
    for (int p = 0; p < NR; p++) rf_rdata[p] = mem[m_raddr[p]];

  typedef struct {
    logic          wv;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [1:0]    qv;
    logic [AW-1:0] qa0;
    logic [AW-1:0] qa1;
    logic [1:0]    rr;
    logic [1:0]    ev;
    logic [DW-1:0] ed0;
    logic [DW-1:0] ed1;
    logic [1:0]    eq;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                              input logic [1:0] qv, input logic [AW-1:0] qa0, input logic [AW-1:0] qa1,
                              input logic [1:0] rr, input logic [1:0] ev,
                              input logic [DW-1:0] ed0, input logic [DW-1:0] ed1, input logic [1:0] eq);
    vec_t v;
    v.wv = wv; v.wa = wa; v.wd = wd; v.qv = qv; v.qa0 = qa0; v.qa1 = qa1;
    v.rr = rr; v.ev = ev; v.ed0 = ed0; v.ed1 = ed1; v.eq = eq;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0h required=%0h", name, cur, act, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [1:0] qv, input logic [AW-1:0] qa0, input logic [AW-1:0] qa1,
                       input logic [1:0] rr);
    wr_valid    = wv;
    wr_addr     = wa;
    wr_data     = wd;
    req_valid   = qv;
    req_addr[0] = qa0;
    req_addr[1] = qa1;
    rsp_ready   = rr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cur++;
  endtask

  initial begin
    // Row layout: wv wa wd | qv qa0 qa1 | rr || ev ed0 ed1 | eq
    tbl.push_back(mk(1, 3, 32'hDEADBEEF, 2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 2'b11));
    tbl.push_back(mk(0, 0, 0,            2'b01, 3, 0, 2'b11, 2'b00, 0, 0, 2'b11));
    tbl.push_back(mk(0, 0, 0,            2'b00, 0, 0, 2'b11, 2'b01, 32'hDEADBEEF, 0, 2'b11));
    tbl.push_back(mk(1, 7, 32'h11,       2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 2'b11));
    tbl.push_back(mk(1, 7, 32'h22,       2'b10, 0, 7, 2'b11, 2'b00, 0, 0, 2'b11));
    tbl.push_back(mk(0, 0, 0,            2'b00, 0, 0, 2'b11, 2'b10, 0, 32'h22, 2'b11));
    tbl.push_back(mk(1, 5, 32'hA5,       2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 2'b11));
    tbl.push_back(mk(1, 9, 32'h99,       2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 2'b11));
    tbl.push_back(mk(0, 0, 0,            2'b01, 5, 0, 2'b10, 2'b00, 0, 0, 2'b11));
    tbl.push_back(mk(1, 5, 32'h5A,       2'b01, 5, 0, 2'b10, 2'b01, 32'hA5, 0, 2'b10));
    tbl.push_back(mk(0, 0, 0,            2'b01, 5, 0, 2'b10, 2'b01, 32'hA5, 0, 2'b10));
    tbl.push_back(mk(0, 0, 0,            2'b01, 5, 0, 2'b10, 2'b01, 32'hA5, 0, 2'b10));
    tbl.push_back(mk(0, 0, 0,            2'b01, 5, 0, 2'b11, 2'b01, 32'hA5, 0, 2'b11));
    tbl.push_back(mk(0, 0, 0,            2'b00, 0, 0, 2'b11, 2'b01, 32'h5A, 0, 2'b11));
    tbl.push_back(mk(0, 0, 0,            2'b11, 9, 9, 2'b11, 2'b00, 0, 0, 2'b11));
    tbl.push_back(mk(0, 0, 0,            2'b00, 0, 0, 2'b11, 2'b11, 32'h99, 32'h99, 2'b11));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, AW'(i), 32'h1000 + i, 2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 2'b11));
    tbl.push_back(mk(0, 0, 0, 2'b01, 0, 0, 2'b11, 2'b00, 0, 0, 2'b11));
    for (int i = 1; i < 8; i++)
      tbl.push_back(mk(0, 0, 0, 2'b01, AW'(i), 0, 2'b11, 2'b01, 32'h1000 + i - 1, 0, 2'b11));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 0, 2'b11, 2'b01, 32'h1007, 0, 2'b11));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 2'b11));

    // Reset state, with requests presented that must not be accepted
    step();
    drive(1, 2, 32'hBAD, 2'b11, 2, 2, 2'b11);
    #1;
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rf_wen", rf_wen, 0);
    chk("rst_rf_ren", rf_ren, 0);
    rst = 1'b0;
    drive(0, 0, 0, 2'b00, 0, 0, 2'b11);

    for (int i = 0; i < tbl.size(); i++) begin
      step();
      drive(tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].qv, tbl[i].qa0, tbl[i].qa1, tbl[i].rr);
      #1;
      chk("wr_ready", wr_ready, 1);
      chk("rsp_valid", rsp_valid, tbl[i].ev);
      chk("req_ready", req_ready, tbl[i].eq);
      chk("rf_read_en", rf_ren, tbl[i].qv & tbl[i].eq);
      chk("rf_write_en", rf_wen, tbl[i].wv);
      if (tbl[i].wv) begin
        chk("rf_write_addr", rf_waddr, tbl[i].wa);
        chk("rf_write_data", rf_wdata, tbl[i].wd);
      end
      if (tbl[i].qv[0]) chk("rf_read_addr0", rf_raddr[0], tbl[i].qa0);
      if (tbl[i].qv[1]) chk("rf_read_addr1", rf_raddr[1], tbl[i].qa1);
      if (tbl[i].ev[0]) chk("rsp_data0", rsp_data[0], tbl[i].ed0);
      if (tbl[i].ev[1]) chk("rsp_data1", rsp_data[1], tbl[i].ed1);
    end

`ifdef SCM_RW_FRONTEND_PERF_CNT_EN
    chk("perf_wr", perf_wr, 14);
    chk("perf_rd", perf_rd, 14);
    chk("perf_fwd", perf_fwd, 1);
`endif

    // Reset while ch0 is stalled in HOLD
    step();
    drive(0, 0, 0, 2'b01, 1, 0, 2'b00);
    #1;
    chk("hr_accept", req_ready, 2'b11);
    step();
    drive(0, 0, 0, 2'b00, 0, 0, 2'b00);
    #1;
    chk("hr_first_valid", rsp_valid, 2'b01);
    chk("hr_first_data", rsp_data[0], 32'h1001);
    chk("hr_first_ready", req_ready, 2'b10);
    step();
    #1;
    chk("hr_hold_valid", rsp_valid, 2'b01);
    chk("hr_hold_data", rsp_data[0], 32'h1001);
    step();
    rst = 1'b1;
    drive(1, 1, 32'hBAD, 2'b11, 1, 1, 2'b11);
    #1;
    chk("hr_rst_valid", rsp_valid, 0);
    chk("hr_rst_ready", req_ready, 0);
    chk("hr_rst_wr_ready", wr_ready, 0);
    chk("hr_rst_rf_wen", rf_wen, 0);
    step();
    #1;
    chk("hr_rst2_valid", rsp_valid, 0);
    chk("hr_rst2_ready", req_ready, 0);
    chk("hr_rst2_rf_ren", rf_ren, 0);
    step();
    rst = 1'b0;
    drive(0, 0, 0, 2'b00, 0, 0, 2'b11);
    #1;
    chk("hr_post_valid", rsp_valid, 0);
    chk("hr_post_ready", req_ready, 2'b11);
    chk("hr_post_wr_ready", wr_ready, 1);
`ifdef SCM_RW_FRONTEND_PERF_CNT_EN
    chk("hr_perf_wr", perf_wr, 0);
    chk("hr_perf_rd", perf_rd, 0);
    chk("hr_perf_fwd", perf_fwd, 0);
`endif
    step();
    drive(0, 0, 0, 2'b01, 1, 0, 2'b11);
    #1;
    chk("hr_reread_acc", rf_ren, 2'b01);
    step();
    drive(0, 0, 0, 2'b00, 0, 0, 2'b11);
    #1;
    chk("hr_reread_valid", rsp_valid, 2'b01);
    chk("hr_reread_data", rsp_data[0], 32'h1001);
    step();
    #1;
    chk("hr_idle_valid", rsp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
